// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_if
// Brief   : Bundles the MEM-stage request/response signals and the 16-bit
//           asynchronous SRAM pins handled by sram_ctrl.
// Revision: 1.0  initial release
// ============================================================================
interface sram_ctrl_if;
  // Pipeline (MEM stage) side
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  // SRAM side
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  // Controller view
  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  // Requester / SRAM-model view
  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl
// Brief   : Splits a 32-bit word access into two 16-bit SRAM half-word
//           accesses (low half first), each WAIT_CYCLES long, and stalls the
//           pipeline through ready until the word access is complete.
// Revision: 1.0  initial release
// ============================================================================
module sram_ctrl #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic      clk,
  input  logic      rst_n,
  sram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Value of the phase counter in the final cycle of a LOW or HIGH phase
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;

  logic        w_req;
  logic        w_last;
  logic [31:0] w_offset;
  logic [16:0] w_index;
  logic        w_unused;

  logic        w_ready;
  logic [17:0] w_sram_addr;
  logic [15:0] w_dq_out;
  logic        w_dq_oe;
  logic        w_we_n;

  assign w_req    = bus.rd_en | bus.wr_en;
  assign w_last   = (cnt_q == LAST_CNT);
  // Word index relative to the data-memory base; bits outside [18:2] drop out
  assign w_offset = addr_q - BASE_ADDR;
  assign w_index  = w_offset[18:2];
  assign w_unused = ^{w_offset[31:19], w_offset[1:0]};

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, read-data capture and SRAM pin decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    w_ready     = 1'b0;
    w_sram_addr = 18'd0;
    w_dq_out    = 16'd0;
    w_dq_oe     = 1'b0;
    w_we_n      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          // Write wins when both requests are asserted together
          addr_d  = bus.address;
          wdata_d = bus.write_data;
          write_d = bus.wr_en;
          cnt_d   = 4'd0;
          state_d = S_LOW;
        end else begin
          w_ready = 1'b1;
        end
      end
      S_LOW: begin
        w_sram_addr = {w_index, 1'b0};
        if (write_q) begin
          w_we_n   = 1'b0;
          w_dq_oe  = 1'b1;
          w_dq_out = wdata_q[15:0];
        end
        if (w_last) begin
          cnt_d   = 4'd0;
          state_d = S_HIGH;
          if (!write_q) rdata_d[15:0] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        w_sram_addr = {w_index, 1'b1};
        if (write_q) begin
          w_we_n   = 1'b0;
          w_dq_oe  = 1'b1;
          w_dq_out = wdata_q[31:16];
        end
        if (w_last) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
          if (!write_q) rdata_d[31:16] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        w_ready = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ready       = w_ready;
  assign bus.read_data   = rdata_q;
  assign bus.sram_addr   = w_sram_addr;
  assign bus.sram_dq_out = w_dq_out;
  assign bus.sram_dq_oe  = w_dq_oe;
  assign bus.sram_we_n   = w_we_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_ctrl
// Brief   : Self-checking bench for sram_ctrl: SRAM models, a word-level
//           reference memory and scoreboard queues of expected pin activity.
// Revision: 1.0  initial release
// ============================================================================
module tb_sram_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  sram_ctrl_if bus();
  sram_ctrl_if bus2();

  sram_ctrl #(.WAIT_CYCLES(3), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple SRAM models, 1K half-words each
  logic [15:0] mem1 [0:1023];
  logic [15:0] mem2 [0:1023];
  always @(posedge clk) if (!bus.sram_we_n)  mem1[bus.sram_addr[9:0]]  <= bus.sram_dq_out;
  always @(posedge clk) if (!bus2.sram_we_n) mem2[bus2.sram_addr[9:0]] <= bus2.sram_dq_out;
  always_comb bus.sram_dq_in  = mem1[bus.sram_addr[9:0]];
  always_comb bus2.sram_dq_in = mem2[bus2.sram_addr[9:0]];

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] dq;
    logic        we_n;
    logic        oe;
  } sram_exp_t;

  sram_exp_t   exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rdata;

  function automatic logic [17:0] half_addr(input logic [31:0] a, input bit hi);
    logic [31:0] off;
    off = a - 32'd1024;
    return {off[18:2], hi};
  endfunction

  // One full word access on the WAIT_CYCLES=3 instance, starting from IDLE
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit perturb, input string tag);
    sram_exp_t   e;
    logic [31:0] er;
    bit          is_wr;
    is_wr = wr;
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < 3; k++) begin
        e.addr = half_addr(a, h[0]);
        e.dq   = (h == 0) ? d[15:0] : d[31:16];
        e.we_n = !is_wr;
        e.oe   = is_wr;
        exp_q.push_back(e);
      end
    end
    if (is_wr) ref_mem[a] = d;
    else       rd_q.push_back(ref_mem.exists(a) ? ref_mem[a] : 32'd0);

    @(posedge clk); #1;
    bus.wr_en = wr; bus.rd_en = rd; bus.address = a; bus.write_data = d;
    @(negedge clk);
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++; $display("FAIL %s req_cycle_ready got=%b want=0", tag, bus.ready);
    end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (perturb && c == 1) begin
        bus.address = a + 32'h40; bus.wr_en = ~wr; bus.write_data = ~d;
      end
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (bus.sram_addr !== e.addr || bus.sram_we_n !== e.we_n || bus.sram_dq_oe !== e.oe ||
          (is_wr && bus.sram_dq_out !== e.dq)) begin
        fails++;
        $display("FAIL %s cycle%0d pins got addr=%h dq=%h we_n=%b oe=%b want addr=%h dq=%h we_n=%b oe=%b",
                 tag, c, bus.sram_addr, bus.sram_dq_out, bus.sram_we_n, bus.sram_dq_oe,
                 e.addr, e.dq, e.we_n, e.oe);
      end
      tests++;
      if (bus.ready !== 1'b0) begin
        fails++; $display("FAIL %s cycle%0d ready got=%b want=0", tag, c, bus.ready);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
      fails++;
      $display("FAIL %s done_cycle got ready=%b we_n=%b oe=%b want 1/1/0",
               tag, bus.ready, bus.sram_we_n, bus.sram_dq_oe);
    end
    if (!is_wr) begin
      er = rd_q.pop_front();
      last_rdata = er;
    end
    tests++;
    if (bus.read_data !== last_rdata) begin
      fails++; $display("FAIL %s read_data got=%h want=%h", tag, bus.read_data, last_rdata);
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0 ||
        bus.sram_addr !== 18'd0 || bus.read_data !== last_rdata) begin
      fails++;
      $display("FAIL %s idle got ready=%b we_n=%b oe=%b addr=%h rdata=%h want 1/1/0/0/%h",
               tag, bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr,
               bus.read_data, last_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0 ||
        bus.sram_addr !== 18'd0 || bus.sram_dq_out !== 16'd0 || bus.read_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_state got ready=%b we_n=%b oe=%b addr=%h dq=%h rdata=%h want 1/1/0/0/0/0",
               bus.ready, bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out, bus.read_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_check("reset_release");
  endtask

  task automatic test_write();
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, "write_1024");
    idle_check("after_write");
  endtask

  task automatic test_read();
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, "read_1024");
    idle_check("after_read");
  endtask

  task automatic test_both();
    access(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0, "rdwr_1032");
    idle_check("after_rdwr");
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 1'b0, "b2b_write");
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, "b2b_read");
    idle_check("after_b2b");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = 32'd1040; bus.write_data = 32'h55AA33CC;
    for (int c = 0; c < 5; c++) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0 || bus.sram_addr !== 18'd0 ||
        bus.sram_dq_out !== 16'd0 || bus.read_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid outputs got we_n=%b oe=%b addr=%h dq=%h rdata=%h want 1/0/0/0/0",
               bus.sram_we_n, bus.sram_dq_oe, bus.sram_addr, bus.sram_dq_out, bus.read_data);
    end
    last_rdata = 32'd0;
    bus.wr_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) idle_check("reset_mid_after");
  endtask

  task automatic test_wait1();
    sram_exp_t e;
    logic [31:0] a;
    a = 32'd1024 + 32'd4 * 32'd131071;
    for (int h = 0; h < 2; h++) begin
      e.addr = half_addr(a, h[0]);
      e.dq   = (h == 0) ? 16'h2222 : 16'h1111;
      e.we_n = 1'b0;
      e.oe   = 1'b1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus2.wr_en = 1'b1; bus2.address = a; bus2.write_data = 32'h11112222;
    @(negedge clk);
    tests++;
    if (bus2.ready !== 1'b0) begin
      fails++; $display("FAIL wait1 req_cycle_ready got=%b want=0", bus2.ready);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      tests++;
      if (bus2.sram_addr !== e.addr || bus2.sram_dq_out !== e.dq || bus2.sram_we_n !== e.we_n ||
          bus2.ready !== 1'b0) begin
        fails++;
        $display("FAIL wait1 cycle%0d got addr=%h dq=%h we_n=%b ready=%b want addr=%h dq=%h we_n=%b ready=0",
                 c, bus2.sram_addr, bus2.sram_dq_out, bus2.sram_we_n, bus2.ready, e.addr, e.dq, e.we_n);
      end
    end
    @(negedge clk);
    tests++;
    if (bus2.ready !== 1'b1) begin
      fails++; $display("FAIL wait1 ready_cycle3 got=%b want=1", bus2.ready);
    end
    bus2.wr_en = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; last_rdata = 32'd0;
    for (int i = 0; i < 1024; i++) begin mem1[i] = 16'd0; mem2[i] = 16'd0; end
    bus.rd_en = 1'b0;  bus.wr_en = 1'b0;  bus.address = 32'd0;  bus.write_data = 32'd0;
    bus2.rd_en = 1'b0; bus2.wr_en = 1'b0; bus2.address = 32'd0; bus2.write_data = 32'd0;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_back_to_back();
    test_reset_mid();
    test_wait1();
    if (exp_q.size() != 0 || rd_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_leftover got=%0d/%0d want=0/0", exp_q.size(), rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
